fp_alu_cmd_sequencer: RTL and testbench

- Clocked front end for the combinational FP_ALU.
- Buffers incoming {para1, para2, ALU_op} commands in a FIFO and drives them onto FP_ALU through a registered operand stage.
- Captures out/zero/under_overflow into a result register with a valid/ready handshake.
- Keeps a saturating count of under/overflow events for the bus-side status logic.

---
 rtl/fp_alu_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fp_alu_cmd_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_cmd_sequencer.sv
// Clocked front end for the combinational FP_ALU: command FIFO, registered operand
// stage, handshaked result register and a saturating under/overflow event counter.
module fp_alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     clr_err,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_para1,
    input  logic [31:0]              cmd_para2,
    input  logic [1:0]               cmd_op,
    output logic [31:0]              para1,
    output logic [31:0]              para2,
    output logic [1:0]               ALU_op,
    input  logic [31:0]              alu_out,
    input  logic                     alu_zero,
    input  logic                     alu_uof,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_out,
    output logic                     res_zero,
    output logic                     res_uof,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         err_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = 66;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    head;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ready_q, ready_d;
    logic             s1_v_q, s1_v_d;
    logic [31:0]      para1_q, para1_d, para2_q, para2_d;
    logic [1:0]       op_q, op_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_out_q, res_out_d;
    logic             res_zero_q, res_zero_d, res_uof_q, res_uof_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             push, pop, adv, res_hs;

    assign head = mem_q[rd_ptr_q];

    // Handshake decode and next-state for FIFO, operand stage, result stage and counter.
    always_comb begin
        adv    = s1_v_q && (!res_valid_q || res_ready);
        push   = cmd_valid && ready_q && !flush;
        pop    = (level_q != '0) && (!s1_v_q || adv) && !flush;
        res_hs = res_valid_q && res_ready;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        s1_v_d      = s1_v_q;
        para1_d     = para1_q;
        para2_d     = para2_q;
        op_d        = op_q;
        res_valid_d = res_valid_q;
        res_out_d   = res_out_q;
        res_zero_d  = res_zero_q;
        res_uof_d   = res_uof_q;
        err_d       = err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            para1_d  = head[65:34];
            para2_d  = head[33:2];
            op_d     = head[1:0];
            s1_v_d   = 1'b1;
        end else if (adv) begin
            s1_v_d = 1'b0;
        end
        level_d = level_q + LW'(push) - LW'(pop);

        if (adv) begin
            res_out_d   = alu_out;
            res_zero_d  = alu_zero;
            res_uof_d   = alu_uof;
            res_valid_d = 1'b1;
        end else if (res_hs) begin
            res_valid_d = 1'b0;
        end

        // Flush drops queued and in-flight work but leaves data registers untouched.
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            s1_v_d      = 1'b0;
            res_valid_d = 1'b0;
        end

        if (clr_err) begin
            err_d = '0;
        end else if (res_hs && res_uof_q && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + CNT_W'(1);
        end

        ready_d = (level_d != LW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ready_q     <= 1'b1;
            s1_v_q      <= 1'b0;
            para1_q     <= '0;
            para2_q     <= '0;
            op_q        <= 2'b00;
            res_valid_q <= 1'b0;
            res_out_q   <= '0;
            res_zero_q  <= 1'b0;
            res_uof_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
            s1_v_q      <= s1_v_d;
            para1_q     <= para1_d;
            para2_q     <= para2_d;
            op_q        <= op_d;
            res_valid_q <= res_valid_d;
            res_out_q   <= res_out_d;
            res_zero_q  <= res_zero_d;
            res_uof_q   <= res_uof_d;
            err_q       <= err_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by level_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_para1, cmd_para2, cmd_op};
        end
    end

    assign cmd_ready = ready_q;
    assign para1     = para1_q;
    assign para2     = para2_q;
    assign ALU_op    = op_q;
    assign res_valid = res_valid_q;
    assign res_out   = res_out_q;
    assign res_zero  = res_zero_q;
    assign res_uof   = res_uof_q;
    assign level     = level_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_fp_alu_cmd_sequencer.sv
// Bench for fp_alu_cmd_sequencer: stub ALU, queue-based result model and saturating
// error-count model, driven by directed and randomized command streams.
module tb_fp_alu_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] out;
        logic        zero;
        logic        uof;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush, clr_err, cmd_valid, cmd_ready;
    logic [31:0]       cmd_para1, cmd_para2, para1, para2, alu_out, res_out;
    logic [1:0]        cmd_op, ALU_op;
    logic              alu_zero, alu_uof, res_valid, res_ready, res_zero, res_uof;
    logic [LW-1:0]     level;
    logic [CNT_W-1:0]  err_count;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   delivered = 0;
    int   err_m = 0;

    fp_alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_para1(cmd_para1), .cmd_para2(cmd_para2), .cmd_op(cmd_op),
        .para1(para1), .para2(para2), .ALU_op(ALU_op),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_uof(alu_uof),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out(res_out), .res_zero(res_zero), .res_uof(res_uof),
        .level(level), .err_count(err_count)
    );

    always #5 clk = ~clk;

    assign alu_out  = para1 + para2;
    assign alu_zero = (alu_out == 32'h0);
    assign alu_uof  = (ALU_op == 2'b11);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        exp_t e;
        e.out  = a + b;
        e.zero = (e.out == 32'h0);
        e.uof  = (op == 2'b11);
        return e;
    endfunction

    // One clock: update the model from pre-edge handshakes, then check after the edge.
    task automatic step();
        logic push, hs, stall;
        exp_t e;
        push  = cmd_valid && cmd_ready;
        hs    = res_valid && res_ready;
        stall = res_valid && !res_ready && !flush;
        if (hs) begin
            chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res_out", res_out, e.out);
                chk("res_zero", 32'(res_zero), 32'(e.zero));
                chk("res_uof", 32'(res_uof), 32'(e.uof));
                delivered++;
                if (!clr_err && e.uof && err_m < (2 ** CNT_W) - 1) err_m++;
            end
        end
        if (clr_err) err_m = 0;
        if (flush) exp_q.delete();
        else if (push) exp_q.push_back(model(cmd_para1, cmd_para2, cmd_op));
        @(posedge clk);
        @(negedge clk);
        chk("err_count", 32'(err_count), 32'(err_m));
        if (stall) begin
            chk("stall_valid", 32'(res_valid), 32'd1);
            if (exp_q.size() != 0) chk("stall_res_out", res_out, exp_q[0].out);
        end
    endtask

    task automatic set_cmd(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        cmd_valid = v;
        cmd_para1 = a;
        cmd_para2 = b;
        cmd_op    = op;
    endtask

    task automatic drain();
        int n;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_res_valid", 32'(res_valid), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_level"}, 32'(level), 32'd0);
        chk({p, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({p, "_err_count"}, 32'(err_count), 32'd0);
        chk({p, "_para1"}, para1, 32'd0);
        chk({p, "_para2"}, para2, 32'd0);
        chk({p, "_ALU_op"}, 32'(ALU_op), 32'd0);
        chk({p, "_res_out"}, res_out, 32'd0);
        chk({p, "_res_zero"}, 32'(res_zero), 32'd0);
        chk({p, "_res_uof"}, 32'(res_uof), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        flush = 1'b0;
        clr_err = 1'b0;
        res_ready = 1'b0;
        set_cmd(1'b0, 32'h0, 32'h0, 2'b00);

        // Reset values before any clock edge.
        #1;
        chk_reset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_reset_level", 32'(level), 32'd0);

        // Single command latency.
        res_ready = 1'b1;
        set_cmd(1'b1, 32'h3F800000, 32'h40000000, 2'b00);
        step();
        chk("lat_n_res_valid", 32'(res_valid), 32'd0);
        chk("lat_n_level", 32'(level), 32'd1);
        cmd_valid = 1'b0;
        step();
        chk("lat_n1_para1", para1, 32'h3F800000);
        chk("lat_n1_para2", para2, 32'h40000000);
        chk("lat_n1_res_valid", 32'(res_valid), 32'd0);
        step();
        chk("lat_n2_res_valid", 32'(res_valid), 32'd1);
        chk("lat_n2_res_out", res_out, 32'h7F800000);
        chk("lat_n2_res_zero", 32'(res_zero), 32'd0);
        chk("lat_n2_res_uof", 32'(res_uof), 32'd0);
        drain();

        // Fill with the consumer stalled, then overflow attempts, then drain in order.
        res_ready = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            set_cmd(1'b1, $urandom, $urandom, 2'($urandom_range(0, 2)));
            step();
        end
        chk("fill_level", 32'(level), 32'(DEPTH));
        chk("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b1, $urandom, $urandom, 2'b00);
            step();
        end
        chk("full_level_held", 32'(level), 32'(DEPTH));
        chk("full_accepted", 32'(exp_q.size()), 32'(DEPTH + 2));
        delivered = 0;
        drain();
        chk("fill_delivered", 32'(delivered), 32'(DEPTH + 2));

        // Back-to-back stream of 16 commands.
        res_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if (i < 16) set_cmd(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
            else cmd_valid = 1'b0;
            step();
            chk("b2b_level_le1", 32'(level <= LW'(1)), 32'd1);
            chk("b2b_res_valid", 32'(res_valid), 32'((i >= 2) && (i <= 17)));
        end
        drain();

        // Random consumer stalls with results that sum to zero.
        for (int i = 0; i < 60; i++) begin
            set_cmd(1'($urandom_range(0, 1)), 32'h00000001, 32'hFFFFFFFF, 2'($urandom_range(0, 2)));
            res_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        // Saturation of the error counter.
        res_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            set_cmd(1'b1, $urandom, $urandom, 2'b11);
            step();
        end
        drain();
        chk("err_saturated", 32'(err_count), 32'd255);

        // clr_err wins over a uof handshake in the same cycle.
        res_ready = 1'b0;
        set_cmd(1'b1, 32'h1, 32'h2, 2'b11);
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 10) begin
            step();
            n++;
        end
        chk("clr_wait_res_valid", 32'(res_valid), 32'd1);
        clr_err = 1'b1;
        res_ready = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_err_priority", 32'(err_count), 32'd0);
        drain();

        // Flush with a partly filled FIFO and both pipeline stages occupied.
        res_ready = 1'b0;
        n = 0;
        while (level != LW'(3) && n < 20) begin
            set_cmd(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
            step();
            n++;
        end
        chk("pre_flush_level", 32'(level), 32'd3);
        chk("pre_flush_res_valid", 32'(res_valid), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_res_valid", 32'(res_valid), 32'd0);
        chk("flush_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_flush_res_valid", 32'(res_valid), 32'd0);
        end

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 10; i++) begin
            set_cmd(1'b1, $urandom, $urandom, 2'b11);
            res_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("pre_reset_err_nonzero", 32'(err_count != '0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        exp_q.delete();
        err_m = 0;
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("recover_cmd_ready", 32'(cmd_ready), 32'd1);
        res_ready = 1'b1;
        set_cmd(1'b1, 32'h40400000, 32'h00000001, 2'b01);
        step();
        delivered = 0;
        drain();
        chk("recover_delivered", 32'(delivered), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
